// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch path: FSM states, PC stepping
// constants and the default memory timeout.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT,
    EXEC,
    HALT,
    FAULT
  } fetch_state_t;

  localparam int unsigned PC_INC          = 4;
  localparam logic [31:0] PC_ALIGN_MASK   = ~32'h3;
  localparam int          DEFAULT_TIMEOUT = 16;

  // True when the low address bits are zero, i.e. a word-aligned target.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits & ~PC_ALIGN_MASK[1:0]) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/grant/response bundle between the fetch
// sequencer (master) and instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an instruction-memory response; expired is
// high once the count has reached TIMEOUT-1.
module fetch_timeout_ctr
  import proc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads the start PC, fetches over the imem
// handshake, presents each instruction for one cycle and advances the PC.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   load_pc,
  fetch_sequencer_if.master   imem,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  input  logic                halt_req,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retire_cnt
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic [CNT_W-1:0]  retire_reg, retire_next;
  logic              tmo_clr, tmo_en, tmo_expired;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      instr_reg  <= '0;
      retire_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      retire_reg <= retire_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    retire_next = retire_reg;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;

    case (state_reg)
      IDLE: state_next = LOAD;

      LOAD: begin
        pc_next    = {load_pc[ADDR_W-1:2], load_pc[1:0] & PC_ALIGN_MASK[1:0]};
        state_next = REQ;
      end

      // Response data arriving while still requesting is deliberately ignored.
      REQ: begin
        if (imem.imem_gnt) begin
          tmo_clr    = 1'b1;
          state_next = WAIT;
        end
      end

      // A response on the final timeout cycle still wins over the fault.
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_next = imem.imem_rdata;
          state_next = EXEC;
        end else if (tmo_expired) begin
          state_next = FAULT;
        end else begin
          tmo_en = 1'b1;
        end
      end

      EXEC: begin
        if (retire_reg != {CNT_W{1'b1}}) begin
          retire_next = retire_reg + CNT_W'(1);
        end
        if (halt_req) begin
          state_next = HALT;
        end else if (redirect_valid) begin
          if (is_word_aligned(redirect_target[1:0])) begin
            pc_next    = redirect_target;
            state_next = REQ;
          end else begin
            state_next = FAULT;
          end
        end else begin
          pc_next    = pc_reg + ADDR_W'(PC_INC);
          state_next = REQ;
        end
      end

      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  assign imem.imem_req  = (state_reg == REQ);
  assign imem.imem_addr = pc_reg;
  assign instr          = instr_reg;
  assign instr_valid    = (state_reg == EXEC);
  assign pc             = pc_reg;
  assign halted         = (state_reg == HALT);
  assign fault          = (state_reg == FAULT);
  assign retire_cnt     = retire_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scripted memory responder with a
// scoreboard of expected (address, instruction) pairs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] load_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [31:0] retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  fetch_sequencer #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_pc         (load_pc),
    .imem            (imem_bus.master),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted),
    .fault           (fault),
    .retire_cnt      (retire_cnt)
  );

  task automatic clear_inputs();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    redirect_valid       = 1'b0;
    redirect_target      = '0;
    halt_req             = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] lp);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    load_pc = lp;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (imem_bus.imem_req !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    ok = (imem_bus.imem_req === 1'b1);
  endtask

  // Runs one fetch; returns at the negedge after the EXEC cycle.
  task automatic do_fetch(input logic [31:0] addr, input int gdly, input int rdly,
                          input logic [31:0] data, input logic rv, input logic [31:0] rt,
                          input logic hr, input logic [31:0] exp_cnt);
    bit   ok;
    bit   stable = 1'b1;
    bit   quiet  = 1'b1;
    exp_t e;
    wait_req(ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL fetch_req: imem_req=%b required 1", imem_bus.imem_req);
      n_err++;
      return;
    end
    n_vec++;
    if (imem_bus.imem_addr !== addr) begin
      $display("FAIL fetch_addr: got %h required %h", imem_bus.imem_addr, addr);
      n_err++;
    end
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr) stable = 1'b0;
    end
    if (gdly > 0) begin
      n_vec++;
      if (!stable) begin
        $display("FAIL stall_addr: req=%b addr=%h required req=1 addr=%h",
                 imem_bus.imem_req, imem_bus.imem_addr, addr);
        n_err++;
      end
    end
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      if (instr_valid !== 1'b0 || fault !== 1'b0 || imem_bus.imem_req !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (!quiet) begin
      $display("FAIL wait_quiet: instr_valid/fault/req active while waiting, required 0");
      n_err++;
    end
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = data;
    sb.push_back('{addr: addr, data: data});
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    n_vec++;
    if (instr_valid !== 1'b1) begin
      $display("FAIL exec_valid: instr_valid=%b required 1", instr_valid);
      n_err++;
    end
    n_vec++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: instr_valid with empty scoreboard, required an entry");
      n_err++;
    end else begin
      e = sb.pop_front();
      if (instr !== e.data || pc !== e.addr) begin
        $display("FAIL exec_instr: got instr=%h pc=%h required instr=%h pc=%h",
                 instr, pc, e.data, e.addr);
        n_err++;
      end
    end
    redirect_valid  = rv;
    redirect_target = rt;
    halt_req        = hr;
    @(negedge clk);
    redirect_valid  = 1'b0;
    halt_req        = 1'b0;
    n_vec++;
    if (instr_valid !== 1'b0 || retire_cnt !== exp_cnt) begin
      $display("FAIL after_exec: instr_valid=%b retire=%0d required 0 and %0d",
               instr_valid, retire_cnt, exp_cnt);
      n_err++;
    end
    $display("fetch addr=%h data=%h gnt_delay=%0d rsp_delay=%0d retire=%0d",
             addr, data, gdly, rdly, retire_cnt);
  endtask

  task automatic test_reset_load();
    reset   = 1'b0;
    load_pc = 32'h00400020;
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if ({pc, instr, imem_bus.imem_addr, retire_cnt} !== '0 ||
        {imem_bus.imem_req, instr_valid, halted, fault} !== 4'b0) begin
      $display("FAIL reset_state: pc=%h instr=%h addr=%h cnt=%0d req=%b iv=%b h=%b f=%b required all 0",
               pc, instr, imem_bus.imem_addr, retire_cnt, imem_bus.imem_req, instr_valid, halted, fault);
      n_err++;
    end
    reset = 1'b1;
    do_fetch(32'h00400020, 0, 0, 32'h20080005, 1'b0, 32'h0, 1'b0, 32'd1);
    n_vec++;
    if (imem_bus.imem_addr !== 32'h00400024) begin
      $display("FAIL next_addr: got %h required 00400024", imem_bus.imem_addr);
      n_err++;
    end
  endtask

  task automatic test_stall();
    do_fetch(32'h00400024, 3, 3, 32'h8C220004, 1'b0, 32'h0, 1'b0, 32'd2);
    n_vec++;
    if (fault !== 1'b0) begin
      $display("FAIL stall_fault: fault=%b required 0", fault);
      n_err++;
    end
  endtask

  task automatic test_redirect();
    do_fetch(32'h00400028, 0, 1, 32'h10000040, 1'b1, 32'h00400100, 1'b0, 32'd3);
    do_fetch(32'h00400100, 1, 0, 32'h08000041, 1'b1, 32'h00400102, 1'b0, 32'd4);
    repeat (3) @(negedge clk);
    n_vec++;
    if (fault !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== 32'h00400100) begin
      $display("FAIL misaligned: fault=%b req=%b pc=%h required 1 0 00400100",
               fault, imem_bus.imem_req, pc);
      n_err++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early = 1'b0;
    do_reset(32'h00002000);
    wait_req(ok);
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    // 16 WAIT cycles with no response; fault must appear only after the last.
    for (int i = 0; i < 15; i++) begin
      if (fault !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    if (fault !== 1'b0) early = 1'b1;
    n_vec++;
    if (!ok || early) begin
      $display("FAIL timeout_early: req_seen=%b early_fault=%b required 1 0", ok, early);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (fault !== 1'b1) begin
      $display("FAIL timeout_fault: fault=%b required 1", fault);
      n_err++;
    end
    do_reset(32'h00003000);
    do_fetch(32'h00003000, 0, 15, 32'hA5A5F00D, 1'b0, 32'h0, 1'b0, 32'd1);
    n_vec++;
    if (fault !== 1'b0) begin
      $display("FAIL timeout_last_rvalid: fault=%b required 0", fault);
      n_err++;
    end
  endtask

  task automatic test_halt_wrap();
    do_reset(32'hFFFFFFFC);
    do_fetch(32'hFFFFFFFC, 0, 0, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'd1);
    do_fetch(32'h00000000, 0, 2, 32'h00100073, 1'b1, 32'h00000100, 1'b1, 32'd2);
    repeat (3) @(negedge clk);
    n_vec++;
    if (halted !== 1'b1 || pc !== 32'h0 || imem_bus.imem_req !== 1'b0 || fault !== 1'b0) begin
      $display("FAIL halt: halted=%b pc=%h req=%b fault=%b required 1 00000000 0 0",
               halted, pc, imem_bus.imem_req, fault);
      n_err++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit stale = 1'b0;
    do_reset(32'h00001003);
    do_fetch(32'h00001000, 0, 0, 32'hCAFE0001, 1'b0, 32'h0, 1'b0, 32'd1);
    wait_req(ok);
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (!ok || {pc, instr, imem_bus.imem_addr, retire_cnt} !== '0 ||
        {imem_bus.imem_req, instr_valid, halted, fault} !== 4'b0) begin
      $display("FAIL async_reset: pc=%h instr=%h addr=%h cnt=%0d req=%b iv=%b required all 0",
               pc, instr, imem_bus.imem_addr, retire_cnt, imem_bus.imem_req, instr_valid);
      n_err++;
    end
    @(negedge clk);
    reset                = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      if (instr_valid !== 1'b0 || instr !== 32'h0) stale = 1'b1;
    end
    imem_bus.imem_rvalid = 1'b0;
    n_vec++;
    if (stale) begin
      $display("FAIL stale_rvalid: instr_valid=%b instr=%h required 0 00000000", instr_valid, instr);
      n_err++;
    end
    do_fetch(32'h00001000, 0, 0, 32'hCAFE0002, 1'b0, 32'h0, 1'b0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_load();
    test_stall();
    test_redirect();
    test_timeout();
    test_halt_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
